// File: rtl/shared_adder_scheduler.sv
// Round-robin scheduler that time-shares one W+2-bit adder among NUM_REQ
// requesters, each asking for a four-operand sum returned over valid/ready.
module shared_adder_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ*W-1:0] req_c,
  input  logic [NUM_REQ*W-1:0] req_d,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W+1:0]         rsp_sum,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_AB = 3'd1,
    S_C  = 3'd2,
    S_D  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [W-1:0]     r_a, r_b, r_c, r_d;
  logic [IDW-1:0]   r_id;
  logic [W+1:0]     r_acc;
  logic [W+1:0]     r_rsp_sum;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_valid;
  logic [15:0]      r_done_cnt;

  logic             w_grant_vld;
  logic [IDW-1:0]   w_grant_idx;
  logic [IDW-1:0]   w_next_ptr;
  logic [IDW-1:0]   w_scan_idx;
  logic             w_hit;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [W+1:0]     w_add_x, w_add_y, w_sum;

  // Round-robin search starting at r_rr_ptr; the first valid requester wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx  = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      w_hit       = req_valid[w_scan_idx] & ~w_grant_vld;
      w_grant_idx = w_hit ? w_scan_idx : w_grant_idx;
      w_grant_vld = w_grant_vld | w_hit;
    end
    w_next_ptr = IDW'((int'(w_grant_idx) + 1) % NUM_REQ);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: fixed three-step accumulate, then wait for response accept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_grant_vld ? S_AB : IDLE;
      S_AB:    w_next_state = S_C;
      S_C:     w_next_state = S_D;
      S_D:     w_next_state = DONE;
      DONE:    w_next_state = rsp_ready ? IDLE : DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output/datapath steering: grant strobe and shared adder operand mux.
  always_comb begin
    w_req_ready = '0;
    w_add_x     = '0;
    w_add_y     = '0;
    if (r_state == IDLE && w_grant_vld && rst_n) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
    case (r_state)
      S_AB: begin
        w_add_x = {2'b00, r_a};
        w_add_y = {2'b00, r_b};
      end
      S_C: begin
        w_add_x = r_acc;
        w_add_y = {2'b00, r_c};
      end
      S_D: begin
        w_add_x = r_acc;
        w_add_y = {2'b00, r_d};
      end
      default: begin
        w_add_x = '0;
        w_add_y = '0;
      end
    endcase
    w_sum = w_add_x + w_add_y;
  end

  // Operand capture, accumulation, response and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_id        <= '0;
      r_acc       <= '0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_done_cnt  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_a      <= req_a[w_grant_idx*W +: W];
            r_b      <= req_b[w_grant_idx*W +: W];
            r_c      <= req_c[w_grant_idx*W +: W];
            r_d      <= req_d[w_grant_idx*W +: W];
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_next_ptr;
          end
        end
        S_AB, S_C: r_acc <= w_sum;
        S_D: begin
          r_rsp_sum   <= w_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign busy      = (r_state != IDLE);
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler: arbitration order, latency,
// response stall, mid-operation reset and counter wrap.
module tb_shared_adder_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b, req_c, req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_sum;
  logic        busy;
  logic [15:0] done_cnt;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;

  shared_adder_scheduler #(.NUM_REQ(4), .W(8), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
    req_c[i*8 +: 8] = 8'(c);
    req_d[i*8 +: 8] = 8'(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_c = 32'd0; req_d = 32'd0;
    tick(); tick();
    total++; if (req_ready !== 4'b0000) begin $display("FAIL reset_req_ready got=%b exp=0000", req_ready); bad++; end
    total++; if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); bad++; end
    total++; if (rsp_id !== 2'd0) begin $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); bad++; end
    total++; if (rsp_sum !== 10'd0) begin $display("FAIL reset_rsp_sum got=%0d exp=0", rsp_sum); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); bad++; end
    total++; if (done_cnt !== 16'd0) begin $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); bad++; end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_ops(0, 255, 255, 255, 255);
    rsp_ready = 1'b1; req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin $display("FAIL single_ready got=%b exp=0001", req_ready); bad++; end
    tick();
    req_valid = 4'b0000; set_ops(0, 0, 0, 0, 0);
    total++; if (busy !== 1'b1) begin $display("FAIL single_busy got=%b exp=1", busy); bad++; end
    tick(); tick();
    total++; if (rsp_valid !== 1'b0) begin $display("FAIL single_early_valid got=%b exp=0", rsp_valid); bad++; end
    tick();
    total++; if (rsp_valid !== 1'b1) begin $display("FAIL single_valid_T4 got=%b exp=1", rsp_valid); bad++; end
    total++; if (rsp_sum !== 10'd1020) begin $display("FAIL single_sum got=%0d exp=1020", rsp_sum); bad++; end
    total++; if (rsp_id !== 2'd0) begin $display("FAIL single_id got=%0d exp=0", rsp_id); bad++; end
    tick();
    exp_done = 1;
    total++; if (rsp_valid !== 1'b0) begin $display("FAIL single_valid_clr got=%b exp=0", rsp_valid); bad++; end
    total++; if (done_cnt !== 16'(exp_done)) begin $display("FAIL single_done_cnt got=%0d exp=%0d", done_cnt, exp_done); bad++; end
    total++; if (rsp_sum !== 10'd1020) begin $display("FAIL single_sum_hold got=%0d exp=1020", rsp_sum); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL single_idle got=%b exp=0", busy); bad++; end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int id;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_done = 0;
    for (int i = 0; i < 4; i++) set_ops(i, i, i, i, i);
    rsp_ready = 1'b1; req_valid = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      exp_rdy = 4'b0001 << id;
      total++; if (req_ready !== exp_rdy) begin $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_rdy); bad++; end
      tick();
      if (g == 4) req_valid = 4'b0000;
      tick(); tick(); tick();
      total++; if (rsp_valid !== 1'b1) begin $display("FAIL rr_valid%0d got=%b exp=1", g, rsp_valid); bad++; end
      total++; if (rsp_id !== 2'(id)) begin $display("FAIL rr_id%0d got=%0d exp=%0d", g, rsp_id, id); bad++; end
      total++; if (rsp_sum !== 10'(4*id)) begin $display("FAIL rr_sum%0d got=%0d exp=%0d", g, rsp_sum, 4*id); bad++; end
      tick();
      exp_done++;
    end
    total++; if (done_cnt !== 16'(exp_done)) begin $display("FAIL rr_done_cnt got=%0d exp=%0d", done_cnt, exp_done); bad++; end
  endtask

  task automatic test_stall();
    set_ops(2, 10, 20, 30, 40);
    rsp_ready = 1'b0; req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin $display("FAIL stall_grant got=%b exp=0100", req_ready); bad++; end
    tick();
    req_valid = 4'b1111;
    tick(); tick(); tick();
    for (int n = 0; n < 10; n++) begin
      total++; if (rsp_valid !== 1'b1) begin $display("FAIL stall_valid%0d got=%b exp=1", n, rsp_valid); bad++; end
      total++; if (rsp_id !== 2'd2) begin $display("FAIL stall_id%0d got=%0d exp=2", n, rsp_id); bad++; end
      total++; if (rsp_sum !== 10'd100) begin $display("FAIL stall_sum%0d got=%0d exp=100", n, rsp_sum); bad++; end
      total++; if (req_ready !== 4'b0000) begin $display("FAIL stall_ready%0d got=%b exp=0000", n, req_ready); bad++; end
      total++; if (busy !== 1'b1) begin $display("FAIL stall_busy%0d got=%b exp=1", n, busy); bad++; end
      tick();
    end
    rsp_ready = 1'b1; req_valid = 4'b0000;
    tick();
    exp_done++;
    total++; if (rsp_valid !== 1'b0) begin $display("FAIL stall_release got=%b exp=0", rsp_valid); bad++; end
    total++; if (done_cnt !== 16'(exp_done)) begin $display("FAIL stall_done_cnt got=%0d exp=%0d", done_cnt, exp_done); bad++; end
  endtask

  task automatic test_pointer();
    set_ops(3, 1, 1, 1, 1);
    set_ops(0, 2, 2, 2, 2);
    rsp_ready = 1'b1; req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b1000) begin $display("FAIL ptr_grant3 got=%b exp=1000", req_ready); bad++; end
    tick(); tick(); tick(); tick();
    total++; if (rsp_id !== 2'd3) begin $display("FAIL ptr_id3 got=%0d exp=3", rsp_id); bad++; end
    total++; if (rsp_sum !== 10'd4) begin $display("FAIL ptr_sum3 got=%0d exp=4", rsp_sum); bad++; end
    tick();
    total++; if (req_ready !== 4'b0001) begin $display("FAIL ptr_grant0 got=%b exp=0001", req_ready); bad++; end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    total++; if (rsp_id !== 2'd0) begin $display("FAIL ptr_id0 got=%0d exp=0", rsp_id); bad++; end
    total++; if (rsp_sum !== 10'd8) begin $display("FAIL ptr_sum0 got=%0d exp=8", rsp_sum); bad++; end
    tick();
    exp_done += 2;
    total++; if (done_cnt !== 16'(exp_done)) begin $display("FAIL ptr_done_cnt got=%0d exp=%0d", done_cnt, exp_done); bad++; end
  endtask

  task automatic test_reset_mid();
    set_ops(1, 9, 9, 9, 9);
    rsp_ready = 1'b1; req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin $display("FAIL mid_grant got=%b exp=0010", req_ready); bad++; end
    tick();
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b0; req_valid = 4'b0010; #1;
    total++; if (busy !== 1'b0) begin $display("FAIL mid_busy got=%b exp=0", busy); bad++; end
    total++; if (rsp_valid !== 1'b0) begin $display("FAIL mid_valid got=%b exp=0", rsp_valid); bad++; end
    total++; if (rsp_sum !== 10'd0) begin $display("FAIL mid_sum got=%0d exp=0", rsp_sum); bad++; end
    total++; if (rsp_id !== 2'd0) begin $display("FAIL mid_id got=%0d exp=0", rsp_id); bad++; end
    total++; if (done_cnt !== 16'd0) begin $display("FAIL mid_done_cnt got=%0d exp=0", done_cnt); bad++; end
    total++; if (req_ready !== 4'b0000) begin $display("FAIL mid_ready got=%b exp=0000", req_ready); bad++; end
    tick();
    rst_n = 1'b1; set_ops(1, 1, 2, 3, 4); #1;
    total++; if (req_ready !== 4'b0010) begin $display("FAIL mid_regrant got=%b exp=0010", req_ready); bad++; end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    total++; if (rsp_valid !== 1'b1) begin $display("FAIL mid_rsp_valid got=%b exp=1", rsp_valid); bad++; end
    total++; if (rsp_sum !== 10'd10) begin $display("FAIL mid_rsp_sum got=%0d exp=10", rsp_sum); bad++; end
    total++; if (rsp_id !== 2'd1) begin $display("FAIL mid_rsp_id got=%0d exp=1", rsp_id); bad++; end
    tick();
    exp_done = 1;
    total++; if (done_cnt !== 16'(exp_done)) begin $display("FAIL mid_done_after got=%0d exp=%0d", done_cnt, exp_done); bad++; end
  endtask

  task automatic test_wrap();
    force dut.r_done_cnt = 16'hFFFF;
    tick();
    release dut.r_done_cnt;
    set_ops(0, 1, 0, 0, 0);
    rsp_ready = 1'b1; req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin $display("FAIL wrap_grant got=%b exp=0001", req_ready); bad++; end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    total++; if (rsp_sum !== 10'd1) begin $display("FAIL wrap_sum got=%0d exp=1", rsp_sum); bad++; end
    tick();
    total++; if (done_cnt !== 16'h0000) begin $display("FAIL wrap_done_cnt got=%h exp=0000", done_cnt); bad++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_pointer();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
